// File: rtl/fp_pkg.sv
// Shared widths, field bundles and helpers for the FP adder pipeline stages.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SIG_W = MAN_W + 4;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_fields_t;

  typedef struct packed {
    logic             sign_l;
    logic             sign_s;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig_l;
    logic [SIG_W-1:0] sig_s;
    logic             eff_sub;
    logic             special;
  } aligned_t;

  // Denormals share the exponent of the smallest normal.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

endpackage

// File: rtl/fp_rshift_sticky.sv
// Combinational significand right shifter producing G/R in the low bits and S in bit 0.
// Sticky collection is enabled by defining ALIGN_STICKY_EN; otherwise bit 0 is forced to 0.
module fp_rshift_sticky
  import fp_pkg::*;
(
  input  logic [SIG_W-1:0] sig_in,
  input  logic [EXP_W-1:0] shamt,
  output logic [SIG_W-1:0] sig_out
);

  localparam logic [EXP_W-1:0] MAX_SH = EXP_W'(SIG_W);

  logic [SIG_W-1:0] shifted;

`ifdef ALIGN_STICKY_EN
  logic [SIG_W-1:0] lost_mask;

  always_comb begin
    shifted   = '0;
    lost_mask = '1;
    if (shamt < MAX_SH) begin
      shifted   = sig_in >> shamt;
      lost_mask = ~({SIG_W{1'b1}} << shamt);
    end
    // S covers the bit landing in position 0 plus everything pushed off the end.
    sig_out = {shifted[SIG_W-1:1], (|(sig_in & lost_mask)) | shifted[0]};
  end
`else
  always_comb begin
    shifted = '0;
    if (shamt < MAX_SH)
      shifted = sig_in >> shamt;
    sig_out = shifted & {{(SIG_W-1){1'b1}}, 1'b0};
  end
`endif

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage exponent alignment for the FP adder: order operands by magnitude, then align the smaller.
// Behaviour of the sticky bit depends on ALIGN_STICKY_EN (see fp_rshift_sticky).
module fp_align_stage
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_a,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [MAN_W-1:0] man_a,
  input  logic             sign_b,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [MAN_W-1:0] man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_l,
  output logic             sign_s,
  output logic [EXP_W-1:0] exp_out,
  output logic [SIG_W-1:0] sig_l,
  output logic [SIG_W-1:0] sig_s,
  output logic             eff_sub,
  output logic             special
);

  typedef struct packed {
    logic             sign_l;
    logic             sign_s;
    logic [EXP_W-1:0] exp_l;
    logic             hid_l;
    logic [MAN_W-1:0] man_l;
    logic             hid_s;
    logic [MAN_W-1:0] man_s;
    logic [EXP_W-1:0] diff;
    logic             eff_sub;
    logic             special;
  } s1_t;

  fp_fields_t a, b;
  logic [EXP_W-1:0] ea, eb;
  logic             ha, hb, a_ge;
  s1_t              s1_next, s1_q;
  logic             s1_valid, s2_adv;
  logic [SIG_W-1:0] shifted_s;
  aligned_t         s2_next, out_q;

  assign a = {sign_a, exp_a, man_a};
  assign b = {sign_b, exp_b, man_b};

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Ties keep A as the larger operand.
  always_comb begin
    ea   = eff_exp(a.exp);
    eb   = eff_exp(b.exp);
    ha   = (a.exp != '0);
    hb   = (b.exp != '0);
    a_ge = {ea, ha, a.man} >= {eb, hb, b.man};
    s1_next         = '0;
    s1_next.eff_sub = a.sign ^ b.sign;
    s1_next.special = (a.exp == '1) || (b.exp == '1);
    if (a_ge) begin
      s1_next.sign_l = a.sign;  s1_next.sign_s = b.sign;
      s1_next.exp_l  = ea;      s1_next.diff   = ea - eb;
      s1_next.hid_l  = ha;      s1_next.man_l  = a.man;
      s1_next.hid_s  = hb;      s1_next.man_s  = b.man;
    end else begin
      s1_next.sign_l = b.sign;  s1_next.sign_s = a.sign;
      s1_next.exp_l  = eb;      s1_next.diff   = eb - ea;
      s1_next.hid_l  = hb;      s1_next.man_l  = b.man;
      s1_next.hid_s  = ha;      s1_next.man_s  = a.man;
    end
  end

  fp_rshift_sticky u_rshift (
    .sig_in  ({s1_q.hid_s, s1_q.man_s, 3'b000}),
    .shamt   (s1_q.diff),
    .sig_out (shifted_s)
  );

  always_comb begin
    s2_next         = '0;
    s2_next.sign_l  = s1_q.sign_l;
    s2_next.sign_s  = s1_q.sign_s;
    s2_next.exp     = s1_q.exp_l;
    s2_next.sig_l   = {s1_q.hid_l, s1_q.man_l, 3'b000};
    s2_next.sig_s   = shifted_s;
    s2_next.eff_sub = s1_q.eff_sub;
    s2_next.special = s1_q.special;
  end

  // Stage 2 drains before stage 1 refills so a full pipe still moves one item per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid)
          out_q <= s2_next;
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid)
          s1_q <= s1_next;
      end
    end
  end

  assign sign_l  = out_q.sign_l;
  assign sign_s  = out_q.sign_s;
  assign exp_out = out_q.exp;
  assign sig_l   = out_q.sig_l;
  assign sig_s   = out_q.sig_s;
  assign eff_sub = out_q.eff_sub;
  assign special = out_q.special;

endmodule

// File: tb/tb_fp_align_stage.sv
// Scoreboard bench for fp_align_stage: a value-level model predicts each aligned result.
module tb_fp_align_stage;
  import fp_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             out_valid, out_ready;
  logic             sign_l, sign_s, eff_sub, special;
  logic [EXP_W-1:0] exp_out;
  logic [SIG_W-1:0] sig_l, sig_s;

  fp_align_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign_a(sign_a), .exp_a(exp_a), .man_a(man_a),
    .sign_b(sign_b), .exp_b(exp_b), .man_b(man_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_l(sign_l), .sign_s(sign_s), .exp_out(exp_out),
    .sig_l(sig_l), .sig_s(sig_s), .eff_sub(eff_sub), .special(special)
  );

  always #5 clk = ~clk;

  typedef struct {
    aligned_t res;
    int       cyc;
  } sb_t;

  sb_t      sb_q[$];
  int       checks = 0;
  int       failures = 0;
  int       cycle = 0;
  int       n_in = 0;
  int       n_out = 0;
  int       ready_mode = 0;
  bit       latency_mode = 0;
  bit       held = 0;
  aligned_t held_val;
  aligned_t got;

  assign got = {sign_l, sign_s, exp_out, sig_l, sig_s, eff_sub, special};

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Value-level reference: order by (effective exponent, significand), align with exact remainder test.
  function automatic aligned_t model(input logic [31:0] a, input logic [31:0] b);
    aligned_t    r;
    longint      ea, eb, ka, kb, el, es, sig_large, sig_small, shifted;
    int          d;
    logic [31:0] lg, sm;
    bit          below;
    ea = (a[30:23] == 0) ? 1 : longint'(a[30:23]);
    eb = (b[30:23] == 0) ? 1 : longint'(b[30:23]);
    ka = ea * (longint'(1) << 24) + ((a[30:23] != 0) ? (longint'(1) << 23) : 0) + longint'(a[22:0]);
    kb = eb * (longint'(1) << 24) + ((b[30:23] != 0) ? (longint'(1) << 23) : 0) + longint'(b[22:0]);
    if (ka >= kb) begin lg = a; sm = b; el = ea; es = eb; end
    else          begin lg = b; sm = a; el = eb; es = ea; end
    d = int'(el - es);
    sig_large = ((lg[30:23] != 0) ? (longint'(1) << 26) : 0) + longint'(lg[22:0]) * 8;
    sig_small = ((sm[30:23] != 0) ? (longint'(1) << 26) : 0) + longint'(sm[22:0]) * 8;
    shifted = (d >= 27) ? 0 : (sig_small >> d);
    below = (d >= 40) ? (sig_small != 0) : ((sig_small % (longint'(1) << (d + 1))) != 0);
    r.sign_l = lg[31];
    r.sign_s = sm[31];
    r.exp    = 8'(el);
    r.sig_l  = 27'(sig_large);
`ifdef ALIGN_STICKY_EN
    r.sig_s  = 27'((shifted & ~longint'(1)) | (below ? 1 : 0));
`else
    r.sig_s  = 27'(shifted & ~longint'(1));
`endif
    r.eff_sub = a[31] ^ b[31];
    r.special = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    return r;
  endfunction

  // Input side: record every accepted item with its predicted result.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      sb_q.push_back('{model({sign_a, exp_a, man_a}, {sign_b, exp_b, man_b}), cycle});
      n_in++;
    end
  end

  // Output side: pop on every transfer, and hold outputs steady while stalled.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      held = 0;
    end else begin
      if (held) begin
        checkOutput("stall_valid_hold", 128'(out_valid), 128'(1));
        checkOutput("stall_data_hold", 128'(got), 128'(held_val));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output got=%0h expected=none", got);
        end else begin
          e = sb_q.pop_front();
          checkOutput("result", 128'(got), 128'(e.res));
          if (latency_mode)
            checkOutput("latency", 128'(cycle - e.cyc), 128'(2));
          n_out++;
        end
        held = 0;
      end else if (out_valid) begin
        held = 1;
        held_val = got;
      end else begin
        held = 0;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    {sign_a, exp_a, man_a} = a;
    {sign_b, exp_b, man_b} = b;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout got=in_ready_low expected=accept");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    checkOutput("drain_empty", 128'(sb_q.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] randOperand();
    return $urandom;
  endfunction

  logic [31:0] dir_a[12] = '{32'h3F800000, 32'h4E800000, 32'h3F800001, 32'h00000001, 32'h40400000,
                             32'h7F800000, 32'h3F800000, 32'h4D000000, 32'h4C800000, 32'h7F800000,
                             32'h00000000, 32'h80000003};
  logic [31:0] dir_b[12] = '{32'h40000000, 32'h3F800000, 32'h3E000000, 32'h00800000, 32'hC0400000,
                             32'h3F800000, 32'hFFC00000, 32'h3F800000, 32'h3F800001, 32'h00000000,
                             32'h00000000, 32'h00000002};

  initial begin
    logic [31:0] a, b;
    int start_in, out_before;
    rst = 1'b1;
    in_valid = 1'b0;
    {sign_a, exp_a, man_a} = '0;
    {sign_b, exp_b, man_b} = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", 128'(out_valid), 128'(0));
    checkOutput("reset_in_ready", 128'(in_ready), 128'(1));
    checkOutput("reset_data", 128'(got), 128'(0));
    @(posedge clk);
    #1;

    // Directed cases back-to-back at full rate with latency checking.
    latency_mode = 1;
    for (int i = 0; i < 12; i++)
      applyStimulus(dir_a[i], dir_b[i]);
    waitDrain();
    latency_mode = 0;

    // Burst starting into a blocked output: exactly two accepts, then in_ready falls.
    ready_mode = 2;
    @(posedge clk);
    #1;
    start_in = n_in;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          a = randOperand();
          b = randOperand();
          if ($urandom_range(0, 1) == 1) b[30:23] = a[30:23] + 8'($urandom_range(0, 30));
          applyStimulus(a, b);
        end
      end
      begin
        repeat (3) @(negedge clk);
        checkOutput("stall_accepts", 128'(n_in - start_in), 128'(2));
        checkOutput("stall_in_ready", 128'(in_ready), 128'(0));
        ready_mode = 1;
      end
    join
    waitDrain();
    checkOutput("burst_count", 128'(n_out), 128'(n_in));

    // Longer randomized run with random output stalls.
    for (int i = 0; i < 40; i++) begin
      a = randOperand();
      b = randOperand();
      if ($urandom_range(0, 2) == 0) b[30:23] = a[30:23] - 8'($urandom_range(0, 30));
      applyStimulus(a, b);
    end
    ready_mode = 0;
    waitDrain();
    checkOutput("random_count", 128'(n_out), 128'(n_in));

    // Reset with two items in flight must discard both.
    ready_mode = 2;
    @(posedge clk);
    #1;
    applyStimulus(32'h3F800000, 32'h40000000);
    applyStimulus(32'h40400000, 32'h3F800000);
    out_before = n_out;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_flush_valid0", 128'(out_valid), 128'(0));
    @(negedge clk);
    checkOutput("reset_flush_valid1", 128'(out_valid), 128'(0));
    sb_q.delete();
    ready_mode = 0;
    repeat (4) @(negedge clk);
    checkOutput("reset_no_emit", 128'(out_valid), 128'(0));
    checkOutput("reset_out_count", 128'(n_out), 128'(out_before));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("[TB] FAIL watchdog got=timeout expected=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
